// File: rtl/keypad_entry_ctrl_pkg.sv
// Keypad entry controller shared definitions:
// key indices, digit lookup and debouncer states.
package keypad_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEB,
    ST_WAIT_REL
  } deb_state_e;

  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_B    = 4'd7;
  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_D    = 4'd15;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] value;
  } key_digit_t;

  // r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
  function automatic key_digit_t key_lookup(
    input logic [3:0] idx
  );
    key_digit_t r;
    r.is_digit = 1'b1;
    r.value    = 4'd0;
    case (idx)
      4'd0:    r.value = 4'd1;
      4'd1:    r.value = 4'd2;
      4'd2:    r.value = 4'd3;
      4'd4:    r.value = 4'd4;
      4'd5:    r.value = 4'd5;
      4'd6:    r.value = 4'd6;
      4'd8:    r.value = 4'd7;
      4'd9:    r.value = 4'd8;
      4'd10:   r.value = 4'd9;
      4'd13:   r.value = 4'd0;
      default: r.is_digit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] onehot_pos(
    input logic [3:0] v
  );
    logic [1:0] p;
    p = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) p = 2'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_debouncer.sv
// Debounces the scanner code and emits one
// key event per stable press.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pressed,
  input  logic [7:0] btn_code,
  output logic       key_valid,
  output logic [3:0] key_code
);

  import keypad_entry_ctrl_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  deb_state_e    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    code_q, code_d;
  logic          kv_d;
  logic [3:0]    kc_d;
  logic          code_ok;

  assign code_ok = btn_pressed &&
                   $onehot(btn_code[7:4]) &&
                   $onehot(btn_code[3:0]);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    code_d  = code_q;
    kv_d    = 1'b0;
    kc_d    = key_code;
    unique case (state)
      ST_IDLE: begin
        if (code_ok) begin
          code_d  = btn_code;
          cnt_d   = CW'(1);
          state_d = ST_DEB;
        end
      end
      ST_DEB: begin
        if (!code_ok || btn_code != code_q) begin
          state_d = ST_IDLE;
        end else if (cnt == LAST) begin
          kv_d    = 1'b1;
          kc_d    = {onehot_pos(code_q[3:0]),
                     onehot_pos(code_q[7:4])};
          cnt_d   = '0;
          state_d = ST_WAIT_REL;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_WAIT_REL: begin
        // any valid code, even a different key, restarts release timing
        if (code_ok) begin
          cnt_d = '0;
        end else if (cnt == LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_WAIT_REL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_WAIT_REL;
      cnt       <= '0;
      code_q    <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      code_q    <= code_d;
      key_valid <= kv_d;
      key_code  <= kc_d;
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced key events
// assembled into a BCD entry with valid/ready handoff.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 64,
  parameter int MAX_DIGITS      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_pressed,
  input  logic [7:0]              btn_code,
  output logic                    key_valid,
  output logic [3:0]              key_code,
  output logic                    entry_valid,
  input  logic                    entry_ready,
  output logic [4*MAX_DIGITS-1:0] entry_bcd,
  output logic [$clog2(MAX_DIGITS+1)-1:0] entry_len,
  output logic                    overflow
);

  import keypad_entry_ctrl_pkg::*;

  localparam int BW = 4 * MAX_DIGITS;
  localparam int LW = $clog2(MAX_DIGITS + 1);
  localparam logic [LW-1:0] LMAX = LW'(MAX_DIGITS);

  key_digit_t    kd;
  logic [BW-1:0] bcd_d;
  logic [LW-1:0] len_d;
  logic          ovf_d;
  logic          ev_d;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk        (clk),
    .reset      (reset),
    .btn_pressed(btn_pressed),
    .btn_code   (btn_code),
    .key_valid  (key_valid),
    .key_code   (key_code)
  );

  assign kd = key_lookup(key_code);

  always_comb begin
    bcd_d = entry_bcd;
    len_d = entry_len;
    ovf_d = overflow;
    ev_d  = entry_valid;
    // buffer is frozen while an entry is pending
    if (entry_valid) begin
      if (entry_ready) begin
        bcd_d = '0;
        len_d = '0;
        ovf_d = 1'b0;
        ev_d  = 1'b0;
      end
    end else if (key_valid) begin
      unique case (1'b1)
        kd.is_digit: begin
          if (entry_len < LMAX) begin
            bcd_d = (entry_bcd << 4) |
                    BW'(kd.value);
            len_d = entry_len + LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        (key_code == KEY_D): begin
          if (entry_len != '0) begin
            bcd_d = entry_bcd >> 4;
            len_d = entry_len - LW'(1);
          end
        end
        (key_code == KEY_STAR): begin
          bcd_d = '0;
          len_d = '0;
          ovf_d = 1'b0;
        end
        (key_code == KEY_HASH): begin
          if (entry_len != '0) ev_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_bcd   <= '0;
      entry_len   <= '0;
      overflow    <= 1'b0;
      entry_valid <= 1'b0;
    end else begin
      entry_bcd   <= bcd_d;
      entry_len   <= len_d;
      overflow    <= ovf_d;
      entry_valid <= ev_d;
    end
  end

endmodule
